// File: rtl/rr_sel_mux.sv
// N-way valid/ready selector with fixed-select or round-robin grant into a one-entry output register.
// One cycle from input transfer to out_valid. A stalled output (out_valid & ~out_ready) deasserts every in_ready.
module rr_sel_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              load;
  logic              xfer;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_idx;
  logic [WIDTH-1:0]  grant_dat;
  logic [NUM_IN-1:0] hi_mask;
  logic [NUM_IN-1:0] hi_valid;

  // Round-robin search: channels at or above the pointer win first, else wrap to the lowest valid.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      hi_mask[i] = (SEL_W'(i) >= rr_ptr_q);
    end
    hi_valid  = in_valid & hi_mask;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else if (|hi_valid) begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (hi_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int i = NUM_IN - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_vld = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end
  end

  assign load = ~out_valid_q | out_ready;
  assign xfer = rst_n & load & grant_vld;

  always_comb begin
    in_ready  = '0;
    grant_dat = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = xfer && (grant_idx == SEL_W'(i));
      if (grant_idx == SEL_W'(i)) begin
        grant_dat = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = grant_dat;
      out_src_d   = grant_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        rr_ptr_d = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_sel_mux.sv
// Randomized and directed checks of rr_sel_mux against a cycle-level behavioural model.
module tb_rr_sel_mux;
  localparam int W = 32;
  localparam int N = 8;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst_n, mode, out_ready;
  logic [S-1:0]   sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_src;
  logic           out_valid;

  logic [5:0]     in_ready6;
  logic [W-1:0]   out_data6;
  logic [S-1:0]   out_src6;
  logic           out_valid6;

  always #5 clk = ~clk;

  rr_sel_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Six-channel instance sharing the low channels, for out-of-range select.
  rr_sel_mux #(.WIDTH(W), .NUM_IN(6), .SEL_W(S)) dut6 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data[6*W-1:0]), .in_valid(in_valid[5:0]), .in_ready(in_ready6),
    .out_data(out_data6), .out_src(out_src6), .out_valid(out_valid6),
    .out_ready(out_ready)
  );

  int n_chk  = 0;
  int n_pass = 0;

  bit          m_valid;
  logic [31:0] m_data;
  int          m_src;
  int          m_ptr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic step();
    int g;
    bit load;
    logic [N-1:0] er;
    #2;
    load = !m_valid || out_ready;
    g = -1;
    if (!mode) begin
      if (int'(sel) < N && in_valid[sel]) g = int'(sel);
    end else begin
      for (int k = 0; k < N; k++) begin
        int idx = (m_ptr + k) % N;
        if (g < 0 && in_valid[idx]) g = idx;
      end
    end
    er = '0;
    if (rst_n && load && g >= 0) er[g] = 1'b1;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (er != '0) begin
      m_valid = 1; m_data = in_data[g*W +: W]; m_src = g;
      if (mode) m_ptr = (g + 1) % N;
    end else if (out_ready) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_src", out_src, m_src);
  endtask

  initial begin
    m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
    rst_n = 0; mode = 0; sel = '0; in_data = '0; in_valid = '0; out_ready = 0;
    step(); step();

    // fixed select
    rst_n = 1; mode = 0; sel = 3; in_data[3*W +: W] = 32'hDEADBEEF;
    in_valid = 8'h08; out_ready = 1;
    step();
    chk("fixed_data", out_data, 32'hDEADBEEF);
    chk("fixed_src", out_src, 3);

    // round-robin fairness, no bubbles
    mode = 1; in_valid = 8'hFF;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'(i + 'h100);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("rr_seq", out_src, k % N);
      chk("rr_nobubble", out_valid, 1);
    end

    // skip and wrap
    in_valid = 8'h20; step(); chk("rr_to5", out_src, 5);
    in_valid = 8'h05; step(); chk("rr_wrap0", out_src, 0);
    step(); chk("rr_skip2", out_src, 2);
    in_valid = 8'h01; step(); chk("rr_again0", out_src, 0);

    // backpressure then drain+reload on the same edge
    in_valid = 8'hFF; out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("stall_src", out_src, 0);
    end
    out_ready = 1; step(); chk("reload_src", out_src, 1);

    // idle fixed select: drain, data holds
    mode = 0; sel = 5; in_valid = 8'hDF;
    step(); chk("idle_drain", out_valid, 0);
    chk("idle_hold", out_data, 32'h101);
    step();

    // out-of-range select on the six-channel instance
    rst_n = 0; step();
    rst_n = 1; mode = 0; sel = 7; in_valid = 8'hFF; out_ready = 1;
    #2 chk("n6_sel7_ready", in_ready6, 6'h00);
    step();
    chk("n6_sel7_valid", out_valid6, 0);
    sel = 5;
    #2 chk("n6_sel5_ready", in_ready6, 6'h20);
    step();
    chk("n6_sel5_src", out_src6, 5);

    // reset mid-transfer with pointer at 4
    mode = 1; rst_n = 0; step();
    rst_n = 1; in_valid = 8'h08; out_ready = 1; step();
    in_valid = 8'h00; out_ready = 0; step();
    rst_n = 0; step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    rst_n = 1; in_valid = 8'hFF; out_ready = 1; step();
    chk("mid_rst_rr0", out_src, 0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 99) >= 2);
      mode      = ($urandom_range(0, 99) < 60);
      sel       = S'($urandom_range(0, 7));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_sel_mux.md
Name: rr_sel_mux

Overview:
- Parametrised N-way, WIDTH-bit selector for the datapath; the next generation of the 8-to-1 32-bit mux tree.
- Adds valid/ready handshakes on every input and on the output, a one-entry registered output stage, and two modes: fixed select and round-robin arbitration.
- Sits between producer units (ALU results, load data, immediates) and a single consumer such as the register-file write port.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 8, number of input channels; legal values 2..16.
- SEL_W, 3, select/index width; must satisfy 2^SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- mode  input  1  0 = fixed select by sel; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready; combinational; at most one bit set.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset, when rst_n=0 at a clock edge:
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer rr_ptr=0.
  - in_ready is 0 during reset.
- Load enable: load = ~out_valid | out_ready. This gives full throughput, with one transfer per cycle when the consumer is always ready.
- Grant in mode=0:
  - grant = sel when sel < NUM_IN and in_valid[sel]=1; otherwise no grant.
  - sel >= NUM_IN never grants.
  - Other channels are ignored even when valid.
- Grant in mode=1:
  - Grant the first i with in_valid[i]=1, searching i = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_IN.
  - No valid input means no grant.
- in_ready[g] = load & grant_exists & (g == grant). All other in_ready bits are 0.
- Transfer on input g: in_valid[g] & in_ready[g]. On that edge:
  - out_data <= in_data[g].
  - out_src <= g.
  - out_valid <= 1.
  - If mode=1, rr_ptr <= (g == NUM_IN-1) ? 0 : g+1.
- rr_ptr behaviour outside round-robin transfers:
  - Unchanged in mode=0.
  - Unchanged when there is no transfer.
- Output drain with no new grant (out_valid & out_ready, no grant): out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and load: the new data replaces the old data in the same edge, and out_valid stays 1.
- Stall (out_valid=1, out_ready=0):
  - out_data, out_src and out_valid hold.
  - All in_ready bits are 0.
- Latency: one cycle from an input transfer to out_valid=1.
- Mode or sel may change on any cycle. The new value takes effect for the grant in that same cycle; an already-registered output is not affected.
- Reset mid-operation: buffered data is discarded (out_valid=0) and rr_ptr returns to 0 regardless of the handshake state.
- No combinational path from in_data to out_data.
- out_ready feeds in_ready combinationally, by design.

Test Plan:
- Reset, then fixed mode: rst_n=0 for 2 cycles, then mode=0, sel=3, in_data[3]=0xDEADBEEF, in_valid=8'h08, out_ready=1 -> in_ready=8'h08; next cycle out_valid=1, out_data=0xDEADBEEF, out_src=3.
- Round-robin fairness: mode=1, in_valid=8'hFF held, out_ready=1, channel i drives data i+0x100 -> out_src sequence 0,1,...,7,0 on consecutive cycles, with no bubbles.
- Round-robin skip and wrap: mode=1, rr_ptr=6 after a grant to 5, in_valid=8'b0000_0101 -> grant 0, then 2; then with only channel 0 valid, grant 0 again.
- Backpressure: out_valid=1, out_ready=0 for 4 cycles while in_valid=8'hFF -> in_ready=0, and out_data/out_src are stable throughout; on out_ready=1, drain and reload occur in the same edge.
- Invalid or idle select: mode=0, sel=5 with in_valid[5]=0, then NUM_IN=6 with sel=7 -> no in_ready; out_valid falls to 0 after the drain; out_data holds its last value.
- Mid-transfer reset: out_valid=1, rr_ptr=4, assert rst_n=0 for one edge -> out_valid=0, out_data=0, rr_ptr=0; the next round-robin grant with in_valid=8'hFF is channel 0.
